// File: rtl/drac_pkg.sv
// Shared fetch-path types for the I-cache line buffer: CPU request/response
// payloads, the line-buffer FSM state and line geometry helpers.
package drac_pkg;

  localparam int unsigned PHY_VIRT_MAX_ADDR_SIZE = 40;
  localparam int unsigned ICACHE_LINE_BITS       = 128;

  // Byte-offset width inside one I-cache line.
  function automatic int unsigned line_offset_bits(input int unsigned line_bits);
    return $clog2(line_bits / 8);
  endfunction

  localparam int unsigned ICACHE_OFFSET_BITS = line_offset_bits(ICACHE_LINE_BITS);

  typedef struct packed {
    logic                              valid;
    logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] vaddr;
    logic                              invalidate_icache;
    logic                              invalidate_buffer;
    logic                              inval_fetch;
  } req_cpu_icache_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        instr_page_fault;
  } resp_icache_cpu_t;

  typedef enum logic [2:0] {
    LB_IDLE   = 3'd0,
    LB_REQ    = 3'd1,
    LB_WAIT   = 3'd2,
    LB_KILL   = 3'd3,
    LB_REPLAY = 3'd4
  } lb_state_t;

endpackage

// File: rtl/icache_line_buffer.sv
// Single-line fetch buffer in front of the I-cache: serves hits from the held
// line, otherwise fetches the whole line and replays the requested word.
module icache_line_buffer
  import drac_pkg::*;
#(
  parameter int unsigned LINE_BITS  = ICACHE_LINE_BITS,
  parameter int unsigned VADDR_BITS = PHY_VIRT_MAX_ADDR_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  req_cpu_icache_t       req_cpu_icache_i,
  output logic                  ic_req_valid_o,
  input  logic                  ic_req_ready_i,
  output logic [VADDR_BITS-1:0] ic_req_vaddr_o,
  input  logic                  ic_resp_valid_i,
  input  logic [LINE_BITS-1:0]  ic_resp_data_i,
  input  logic                  ic_resp_xcpt_i,
  output logic                  ic_flush_o,
  output resp_icache_cpu_t      resp_icache_cpu_o,
  output logic                  busy_o
);

  localparam int unsigned OFF_BITS = line_offset_bits(LINE_BITS);
  localparam int unsigned TAG_BITS = VADDR_BITS - OFF_BITS;
  localparam int unsigned IDX_BITS = OFF_BITS - 2;

  lb_state_t state_q, state_d;

  logic                 buf_valid_q, buf_valid_d;
  logic [TAG_BITS-1:0]  buf_tag_q,   buf_tag_d;
  logic [LINE_BITS-1:0] buf_data_q,  buf_data_d;
  logic                 buf_xcpt_q,  buf_xcpt_d;
  logic [TAG_BITS-1:0]  miss_tag_q,  miss_tag_d;
  logic [IDX_BITS-1:0]  miss_idx_q,  miss_idx_d;

  resp_icache_cpu_t resp_q, resp_d;
  logic             ic_req_valid_q, ic_req_valid_d;
  logic             busy_q, busy_d;
  logic             flush_q, flush_d;

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic                in_idle, hit, hit_resp, start_miss, fill;
  logic                unused_vaddr;

  assign req_tag      = req_cpu_icache_i.vaddr[VADDR_BITS-1:OFF_BITS];
  assign req_idx      = req_cpu_icache_i.vaddr[OFF_BITS-1:2];
  assign unused_vaddr = ^req_cpu_icache_i.vaddr;

  // A hit while the buffer is being invalidated is treated as a miss so the fetch still completes.
  assign in_idle    = (state_q == LB_IDLE);
  assign hit        = in_idle && req_cpu_icache_i.valid && buf_valid_q && (buf_tag_q == req_tag);
  assign hit_resp   = hit && !req_cpu_icache_i.invalidate_buffer && !req_cpu_icache_i.inval_fetch;
  assign start_miss = in_idle && req_cpu_icache_i.valid && !req_cpu_icache_i.inval_fetch &&
                      !(hit && !req_cpu_icache_i.invalidate_buffer);
  assign fill       = (state_q == LB_WAIT) && ic_resp_valid_i && !req_cpu_icache_i.inval_fetch;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= LB_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a killed miss either drops straight to idle or drains its line in KILL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LB_IDLE: if (start_miss) state_d = LB_REQ;
      LB_REQ: begin
        if (req_cpu_icache_i.inval_fetch) state_d = ic_req_ready_i ? LB_KILL : LB_IDLE;
        else if (ic_req_ready_i)          state_d = LB_WAIT;
      end
      LB_WAIT: begin
        if (req_cpu_icache_i.inval_fetch) state_d = ic_resp_valid_i ? LB_IDLE : LB_KILL;
        else if (ic_resp_valid_i)         state_d = LB_REPLAY;
      end
      LB_KILL:   if (ic_resp_valid_i) state_d = LB_IDLE;
      LB_REPLAY: state_d = LB_IDLE;
      default:   state_d = LB_IDLE;
    endcase
  end

  // Next values for the buffer, miss latch and all registered outputs.
  always_comb begin
    buf_valid_d    = buf_valid_q;
    buf_tag_d      = buf_tag_q;
    buf_data_d     = buf_data_q;
    buf_xcpt_d     = buf_xcpt_q;
    miss_tag_d     = miss_tag_q;
    miss_idx_d     = miss_idx_q;
    resp_d         = '0;
    ic_req_valid_d = (state_d == LB_REQ);
    busy_d         = (state_d == LB_REQ) || (state_d == LB_WAIT) || (state_d == LB_KILL);
    flush_d        = req_cpu_icache_i.invalidate_icache;

    if (start_miss) begin
      miss_tag_d = req_tag;
      miss_idx_d = req_idx;
    end

    if (hit_resp) begin
      resp_d.valid            = 1'b1;
      resp_d.data             = 32'(buf_data_q >> {req_idx, 5'b0});
      resp_d.instr_page_fault = buf_xcpt_q;
    end

    if (fill) begin
      buf_valid_d             = 1'b1;
      buf_tag_d               = miss_tag_q;
      buf_data_d              = ic_resp_data_i;
      buf_xcpt_d              = ic_resp_xcpt_i;
      resp_d.valid            = 1'b1;
      resp_d.data             = 32'(ic_resp_data_i >> {miss_idx_q, 5'b0});
      resp_d.instr_page_fault = ic_resp_xcpt_i;
    end

    if (req_cpu_icache_i.invalidate_buffer || req_cpu_icache_i.invalidate_icache) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_valid_q    <= 1'b0;
      buf_tag_q      <= '0;
      buf_data_q     <= '0;
      buf_xcpt_q     <= 1'b0;
      miss_tag_q     <= '0;
      miss_idx_q     <= '0;
      resp_q         <= '0;
      ic_req_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      buf_valid_q    <= buf_valid_d;
      buf_tag_q      <= buf_tag_d;
      buf_data_q     <= buf_data_d;
      buf_xcpt_q     <= buf_xcpt_d;
      miss_tag_q     <= miss_tag_d;
      miss_idx_q     <= miss_idx_d;
      resp_q         <= resp_d;
      ic_req_valid_q <= ic_req_valid_d;
      busy_q         <= busy_d;
      flush_q        <= flush_d;
    end
  end

  assign ic_req_valid_o    = ic_req_valid_q;
  assign ic_req_vaddr_o    = {miss_tag_q, OFF_BITS'(0)};
  assign ic_flush_o        = flush_q;
  assign busy_o            = busy_q;
  assign resp_icache_cpu_o = resp_q;

endmodule

// File: tb/tb_icache_line_buffer.sv
// Randomised and directed bench for icache_line_buffer against a one-line
// buffer model kept as plain variables.
module tb_icache_line_buffer;
  import drac_pkg::*;

  logic             clk = 1'b0;
  logic             rstn;
  req_cpu_icache_t  req;
  logic             ic_req_valid;
  logic             ready;
  logic [39:0]      ic_req_vaddr;
  logic             rvalid;
  logic [127:0]     rdata;
  logic             rxcpt;
  logic             flush;
  resp_icache_cpu_t resp;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  icache_line_buffer #(.LINE_BITS(128), .VADDR_BITS(40)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_cpu_icache_i(req),
    .ic_req_valid_o(ic_req_valid), .ic_req_ready_i(ready), .ic_req_vaddr_o(ic_req_vaddr),
    .ic_resp_valid_i(rvalid), .ic_resp_data_i(rdata), .ic_resp_xcpt_i(rxcpt),
    .ic_flush_o(flush), .resp_icache_cpu_o(resp), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference: whether a line is held, which line, its contents and fault flag.
  bit           m_valid;
  logic [35:0]  m_line;
  logic [127:0] m_data;
  logic         m_xcpt;

  function automatic bit model_hit(input logic [39:0] va);
    return m_valid && (m_line == va[39:4]);
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [39:0] va);
    logic [127:0] s;
    s = line >> (32 * va[3:2]);
    return s[31:0];
  endfunction

  typedef struct {
    int          nreq;
    logic [39:0] raddr;
    bit          rv;
    logic [31:0] rd;
    logic        rpf;
    int          lat;
    bit          tmo;
    bit          busy_at_resp;
    bit          resp_after;
    bit          proto_bad;
  } fres_t;

  // Issue one fetch and play the I-cache side until the CPU response appears.
  task automatic fetch(input logic [39:0] va, input logic [127:0] line, input logic xcpt,
                       input int rdy_dly, input int rsp_dly, input bit inv_on_fill,
                       output fres_t r);
    int req_at, acc_at;
    bit sent;
    r = '{default: 0};
    req_at = -1; acc_at = -1; sent = 0;
    req.valid = 1'b1; req.vaddr = va;
    @(posedge clk); #1;
    req.valid = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      ready = 1'b0; rvalid = 1'b0; req.invalidate_buffer = 1'b0;
      if (resp.valid) begin
        r.rv = 1; r.rd = resp.data; r.rpf = resp.instr_page_fault; r.lat = c;
        r.busy_at_resp = busy;
        break;
      end
      if (resp.data != 32'd0 || resp.instr_page_fault) r.proto_bad = 1;
      if (ic_req_valid) begin
        if (req_at < 0) begin req_at = c; r.raddr = ic_req_vaddr; end
        if (ic_req_vaddr != r.raddr || !busy) r.proto_bad = 1;
        if (c - req_at >= rdy_dly) begin ready = 1'b1; acc_at = c; r.nreq++; end
      end else if (acc_at >= 0 && !sent && c - acc_at >= rsp_dly) begin
        rvalid = 1'b1; rdata = line; rxcpt = xcpt; sent = 1;
        req.invalidate_buffer = inv_on_fill;
      end
      @(posedge clk); #1;
    end
    ready = 1'b0; rvalid = 1'b0; req.invalidate_buffer = 1'b0; rdata = '0; rxcpt = 1'b0;
    if (!r.rv) r.tmo = 1;
    else begin
      @(posedge clk); #1;
      r.resp_after = resp.valid;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; ready = 1'b0; rvalid = 1'b0; rdata = '1; rxcpt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ic_req_valid !== 1'b0) begin failures++; $display("FAIL reset_ic_req_valid got=%b exp=0", ic_req_valid); end
    checks++; if (ic_req_vaddr !== 40'd0) begin failures++; $display("FAIL reset_ic_req_vaddr got=%h exp=0", ic_req_vaddr); end
    checks++; if (flush !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flush_busy got=%b%b exp=00", flush, busy); end
    checks++; if (resp !== '0) begin failures++; $display("FAIL reset_resp got=%h exp=0", resp); end
    rdata = '0; rxcpt = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    m_valid = 0;
  endtask

  task automatic test_cold_miss_and_hit();
    fres_t r;
    fetch(40'h80000004, 128'h44443333_22221111_00001111_DEADBEEF, 1'b0, 1, 2, 0, r);
    checks++; if (r.tmo) begin failures++; $display("FAIL cold_timeout got=no_resp exp=resp"); end
    checks++; if (r.nreq !== 1 || r.raddr !== 40'h80000000) begin failures++; $display("FAIL cold_icreq got=%0d@%h exp=1@80000000", r.nreq, r.raddr); end
    checks++; if (r.rd !== 32'h00001111 || r.rpf !== 1'b0) begin failures++; $display("FAIL cold_data got=%h/%b exp=00001111/0", r.rd, r.rpf); end
    checks++; if (r.busy_at_resp || r.resp_after || r.proto_bad) begin failures++; $display("FAIL cold_protocol got=%b%b%b exp=000", r.busy_at_resp, r.resp_after, r.proto_bad); end
    m_valid = 1; m_line = 36'h8000000; m_data = 128'h44443333_22221111_00001111_DEADBEEF; m_xcpt = 0;
    fetch(40'h8000000C, '0, 1'b0, 0, 1, 0, r);
    checks++; if (r.nreq !== 0 || r.lat !== 1) begin failures++; $display("FAIL hit_latency got=nreq%0d lat%0d exp=nreq0 lat1", r.nreq, r.lat); end
    checks++; if (r.rd !== 32'h44443333) begin failures++; $display("FAIL hit_data got=%h exp=44443333", r.rd); end
  endtask

  task automatic test_kill_in_wait();
    fres_t r;
    req.valid = 1'b1; req.vaddr = 40'h90000010;
    @(posedge clk); #1;
    req.valid = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; req.inval_fetch = 1'b1;
    @(posedge clk); #1;
    req.inval_fetch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b1 || resp.valid !== 1'b0) begin failures++; $display("FAIL kill_wait_busy got=%b/%b exp=1/0", busy, resp.valid); end
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = {4{32'hCAFE0001}};
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
    checks++; if (busy !== 1'b0 || resp.valid !== 1'b0) begin failures++; $display("FAIL kill_drain got=%b/%b exp=0/0", busy, resp.valid); end
    @(posedge clk); #1;
    checks++; if (resp.valid !== 1'b0) begin failures++; $display("FAIL kill_no_resp got=%b exp=0", resp.valid); end
    fetch(40'h90000010, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 0, 1, 0, r);
    checks++; if (r.nreq !== 1 || r.rd !== 32'h1) begin failures++; $display("FAIL kill_refetch got=%0d/%h exp=1/00000001", r.nreq, r.rd); end
    m_valid = 1; m_line = 36'h9000001; m_data = {32'h4, 32'h3, 32'h2, 32'h1}; m_xcpt = 0;
  endtask

  task automatic test_kill_in_req();
    fres_t r;
    req.valid = 1'b1; req.vaddr = 40'hA0000000;
    @(posedge clk); #1;
    req.valid = 1'b0; req.inval_fetch = 1'b1;
    @(posedge clk); #1;
    req.inval_fetch = 1'b0;
    checks++; if (ic_req_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL kill_req got=%b/%b exp=0/0", ic_req_valid, busy); end
    @(posedge clk); #1;
    checks++; if (resp.valid !== 1'b0) begin failures++; $display("FAIL kill_req_resp got=%b exp=0", resp.valid); end
    fetch(40'hA0000000, {4{32'h0A0A0A0A}}, 1'b0, 2, 1, 0, r);
    checks++; if (r.nreq !== 1 || r.rd !== 32'h0A0A0A0A) begin failures++; $display("FAIL kill_req_refetch got=%0d/%h exp=1/0a0a0a0a", r.nreq, r.rd); end
    m_valid = 1; m_line = 36'hA000000; m_data = {4{32'h0A0A0A0A}}; m_xcpt = 0;
  endtask

  task automatic test_fill_with_invalidate();
    fres_t r;
    logic [127:0] ln;
    ln = {32'h11, 32'h22, 32'h33, 32'h44};
    fetch(40'hB0000008, ln, 1'b0, 0, 1, 1, r);
    checks++; if (!r.rv || r.rd !== 32'h22 || r.resp_after) begin failures++; $display("FAIL fillinv_resp got=%b/%h/%b exp=1/00000022/0", r.rv, r.rd, r.resp_after); end
    m_valid = 0;
    fetch(40'hB0000008, ln, 1'b0, 0, 1, 0, r);
    checks++; if (r.nreq !== 1) begin failures++; $display("FAIL fillinv_refetch got=nreq%0d exp=nreq1", r.nreq); end
    m_valid = 1; m_line = 36'hB000000; m_data = ln; m_xcpt = 0;
  endtask

  task automatic test_invalidate_icache();
    fres_t r;
    fetch(40'hB0000000, '0, 1'b0, 0, 1, 0, r);
    checks++; if (r.nreq !== 0 || r.rd !== 32'h44) begin failures++; $display("FAIL flush_prehit got=%0d/%h exp=0/00000044", r.nreq, r.rd); end
    req.invalidate_icache = 1'b1;
    @(posedge clk); #1;
    req.invalidate_icache = 1'b0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL flush_pulse got=%b exp=1", flush); end
    @(posedge clk); #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_width got=%b exp=0", flush); end
    m_valid = 0;
    fetch(40'hB0000004, {4{32'h5A5A5A5A}}, 1'b0, 0, 1, 0, r);
    checks++; if (r.nreq !== 1) begin failures++; $display("FAIL flush_miss got=nreq%0d exp=nreq1", r.nreq); end
    m_valid = 1; m_line = 36'hB000000; m_data = {4{32'h5A5A5A5A}}; m_xcpt = 0;
  endtask

  task automatic test_page_fault();
    fres_t r;
    fetch(40'hC0000000, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b1, 1, 1, 0, r);
    checks++; if (r.nreq !== 1 || r.rpf !== 1'b1 || r.rd !== 32'hA) begin failures++; $display("FAIL pf_fill got=%0d/%b/%h exp=1/1/0000000a", r.nreq, r.rpf, r.rd); end
    for (int i = 1; i < 4; i++) begin
      fetch(40'hC0000000 + 40'(4 * i), '0, 1'b0, 0, 1, 0, r);
      checks++; if (r.nreq !== 0 || r.rpf !== 1'b1 || r.rd !== 32'(10 + i)) begin failures++; $display("FAIL pf_hit got=%0d/%b/%h exp=0/1/%h", r.nreq, r.rpf, r.rd, 32'(10 + i)); end
    end
    m_valid = 1; m_line = 36'hC000000; m_data = {32'hD, 32'hC, 32'hB, 32'hA}; m_xcpt = 1;
  endtask

  task automatic test_reset_mid_miss();
    fres_t r;
    req.valid = 1'b1; req.vaddr = 40'hD0000000;
    @(posedge clk); #1;
    req.valid = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ic_req_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%b/%b exp=0/0", busy, ic_req_valid); end
    @(posedge clk); #1;
    rstn = 1'b1; m_valid = 0;
    rvalid = 1'b1; rdata = {4{32'hBADBAD00}};
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
    checks++; if (resp.valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stale_resp got=%b/%b exp=0/0", resp.valid, busy); end
    @(posedge clk); #1;
    checks++; if (resp.valid !== 1'b0) begin failures++; $display("FAIL stale_resp2 got=%b exp=0", resp.valid); end
    fetch(40'hD0000000, {4{32'h600D0000}}, 1'b0, 0, 1, 0, r);
    checks++; if (r.nreq !== 1 || r.rd !== 32'h600D0000) begin failures++; $display("FAIL post_reset_fetch got=%0d/%h exp=1/600d0000", r.nreq, r.rd); end
    m_valid = 1; m_line = 36'hD000000; m_data = {4{32'h600D0000}}; m_xcpt = 0;
  endtask

  task automatic test_random();
    fres_t r;
    logic [39:0] bases [3];
    logic [39:0] va;
    logic [127:0] ln;
    logic xc;
    bit inv, exp_hit;
    logic [31:0] exp_word;
    logic exp_pf;
    bases[0] = 40'h00_8000_0000; bases[1] = 40'h00_8000_0040; bases[2] = 40'h12_3400_0000;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        req.invalidate_buffer = 1'b1;
        @(posedge clk); #1;
        req.invalidate_buffer = 1'b0;
        m_valid = 0;
      end
      va  = bases[$urandom_range(0, 2)] + 40'(4 * $urandom_range(0, 3));
      ln  = {$urandom, $urandom, $urandom, $urandom};
      xc  = ($urandom_range(0, 5) == 0);
      inv = ($urandom_range(0, 7) == 0);
      exp_hit  = model_hit(va);
      exp_word = word_of(exp_hit ? m_data : ln, va);
      exp_pf   = exp_hit ? m_xcpt : xc;
      fetch(va, ln, xc, $urandom_range(0, 3), $urandom_range(1, 3), inv, r);
      checks++; if (r.tmo) begin failures++; $display("FAIL rnd_timeout it=%0d va=%h", it, va); end
      checks++; if (r.nreq !== (exp_hit ? 0 : 1)) begin failures++; $display("FAIL rnd_nreq it=%0d got=%0d exp=%0d", it, r.nreq, exp_hit ? 0 : 1); end
      checks++; if (r.rd !== exp_word || r.rpf !== exp_pf) begin failures++; $display("FAIL rnd_data it=%0d got=%h/%b exp=%h/%b", it, r.rd, r.rpf, exp_word, exp_pf); end
      checks++; if (r.resp_after || r.proto_bad || r.busy_at_resp) begin failures++; $display("FAIL rnd_protocol it=%0d got=%b%b%b exp=000", it, r.resp_after, r.proto_bad, r.busy_at_resp); end
      if (exp_hit) begin
        checks++; if (r.lat !== 1) begin failures++; $display("FAIL rnd_hit_lat it=%0d got=%0d exp=1", it, r.lat); end
      end else begin
        checks++; if (r.raddr !== {va[39:4], 4'h0}) begin failures++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, r.raddr, {va[39:4], 4'h0}); end
        m_valid = !inv; m_line = va[39:4]; m_data = ln; m_xcpt = xc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_kill_in_wait();
    test_kill_in_req();
    test_fill_with_invalidate();
    test_invalidate_icache();
    test_page_fault();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_line_buffer.md
ICACHE_LINE_BUFFER -- requirements
Module: icache_line_buffer

Interface
REQ-001 SHALL have parameter LINE_BITS, default 128, meaning the I-cache line width in bits (a multiple of 32).
REQ-002 SHALL have parameter VADDR_BITS, default 40, meaning the fetch virtual address width (PHY_VIRT_MAX_ADDR_SIZE).
REQ-003 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_cpu_icache_i  in  req_cpu_icache_t  fetch request: valid, vaddr, invalidate_icache, invalidate_buffer, inval_fetch.
REQ-006 SHALL have port ic_req_valid_o  out  1  line request to the I-cache.
REQ-007 SHALL have port ic_req_ready_i  in  1  I-cache accepts the line request.
REQ-008 SHALL have port ic_req_vaddr_o  out  VADDR_BITS  line-aligned request address; low log2(LINE_BITS/8) bits are zero.
REQ-009 SHALL have port ic_resp_valid_i  in  1  line return strobe.
REQ-010 SHALL have port ic_resp_data_i  in  LINE_BITS  returned line.
REQ-011 SHALL have port ic_resp_xcpt_i  in  1  instruction page fault on the returned line.
REQ-012 SHALL have port ic_flush_o  out  1  single-cycle I-cache flush pulse.
REQ-013 SHALL have port resp_icache_cpu_o  out  resp_icache_cpu_t  valid, 32-bit data, instr_page_fault.
REQ-014 SHALL have port busy_o  out  1  miss in progress; new fetch requests are ignored while it is high.

Function
REQ-015 SHALL hold one line: tag (vaddr above the line offset), data, xcpt and a valid bit.
REQ-016 SHALL define a hit as req.valid, buffer valid and tag match while in IDLE.
REQ-017 SHALL respond to a hit in the next cycle: resp.valid=1, data=word vaddr[3:2] (for LINE_BITS=128), instr_page_fault=stored xcpt.
REQ-018 SHALL use FSM states IDLE, REQ, WAIT, KILL and REPLAY.
REQ-019 SHALL, on a miss in IDLE, latch vaddr and go to REQ.
REQ-020 SHALL hold ic_req_valid_o=1 with a stable address in REQ, and go to WAIT on ic_req_ready_i.
REQ-021 SHALL, in WAIT on ic_resp_valid_i, write the line, tag and xcpt, set the buffer valid bit and go to REPLAY.
REQ-022 SHALL, in REPLAY, output resp.valid=1 with the latched word and xcpt, then return to IDLE.
REQ-023 SHALL drive busy_o=1 in REQ, WAIT and KILL, and 0 in IDLE and REPLAY.
REQ-024 SHALL ignore req.valid in REPLAY; the next request is evaluated in IDLE.
REQ-025 SHALL handle inval_fetch by state:
- REQ without ready: go to IDLE and produce no response.
- REQ with ready in the same cycle: go to KILL.
- WAIT: go to KILL.
- KILL: swallow the next ic_resp_valid_i with no fill and no response, then go to IDLE.
- In all cases the REPLAY response for that miss is suppressed.
REQ-026 SHALL clear the buffer valid bit in the same cycle as invalidate_buffer.
REQ-027 SHALL give invalidate_buffer priority over a fill in the same cycle: the REPLAY response is still produced, but the line is not retained.
REQ-028 SHALL, on invalidate_icache, register ic_flush_o=1 for exactly one cycle and clear the buffer valid bit.
REQ-029 SHALL suppress any hit response in a cycle where invalidate_buffer or inval_fetch is asserted.
REQ-030 SHALL keep resp.valid at 0 in every cycle other than those required by REQ-017 and REQ-022.
REQ-031 SHALL tie resp data and xcpt to zero when resp.valid=0.

Reset
REQ-032 SHALL, while rstn_i=0, force:
- FSM to IDLE; buffer valid, tag, data and xcpt to 0.
- ic_req_valid_o, ic_flush_o, busy_o and resp.valid to 0; ic_req_vaddr_o to 0.
REQ-033 SHALL abandon an outstanding miss on reset, with no response after reset release; a stale ic_resp_valid_i received in IDLE is ignored.

Structure
REQ-034 SHALL take req_cpu_icache_t, resp_icache_cpu_t, the line-buffer FSM state enum and the line-offset width constant from drac_pkg.
REQ-035 SHALL be a single module with no sub-modules; the word-select mux is inline.

Verification
REQ-036 Bench SHALL cover a cold miss:
- Stimulus: req vaddr=0x80000004, ready=1 on the cycle after REQ is entered, response two cycles later with data=0x44443333_22221111_00001111_DEADBEEF.
- Required: one ic_req with address 0x80000000, then resp.valid=1 with data=0x00001111 in the REPLAY cycle.
REQ-037 Bench SHALL cover a hit after fill: req vaddr=0x8000000C -> resp.valid=1 one cycle later with data=0x44443333 and no ic_req_valid_o.
REQ-038 Bench SHALL cover a kill in WAIT: inval_fetch asserted in WAIT -> busy_o stays high until ic_resp_valid_i, no resp.valid, buffer not filled (a later request to the same vaddr misses).
REQ-039 Bench SHALL cover a simultaneous fill and invalidate_buffer: one response is produced, and the next request to the same line issues a new ic_req.
REQ-040 Bench SHALL cover invalidate_icache: ic_flush_o high for exactly one cycle, and the next request to the previously buffered line misses.
REQ-041 Bench SHALL cover a page fault: ic_resp_xcpt_i=1 on fill -> instr_page_fault=1 on the REPLAY response and on every later hit to that line.
